// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: command and state encodings for the counter scheduler
package counter_sched_pkg;
    typedef enum logic [1:0] {CMD_LOAD = 2'd0, CMD_UP, CMD_DOWN, CMD_HOLD} cmd_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest index at or after the pointer wins
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr,
    output logic [N_REQ-1:0]         win,
    output logic                     any
);
    always_comb begin
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr) + k) % N_REQ]) begin
                win = '0;
                win[(int'(rr) + k) % N_REQ] = 1'b1;
            end
        end
    end
    assign any = |req;
endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin sequencer driving one shared up/down counter
module counter_scheduler
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] cmd,
    input  logic [W*N_REQ-1:0] arg,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    output logic               ctr_en,
    output logic               ctr_load,
    output logic               ctr_hold,
    output logic               ctr_up,
    output logic               ctr_down,
    output logic [W-1:0]       ctr_init
);
    localparam int RW = $clog2(N_REQ);
    state_t state, nxt;
    cmd_t cmd_q;
    logic [W-1:0] arg_q, remain;
    logic [RW-1:0] rr, win_idx, g_idx;
    logic [N_REQ-1:0] win;
    logic any, exec_last;
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req(req),
        .rr (rr),
        .win(win),
        .any(any)
    );
    always_comb begin
        win_idx = '0;
        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_idx = win[i] ? RW'(i) : win_idx;
            g_idx = grant[i] ? RW'(i) : g_idx;
        end
    end
    // remain <= 1 also covers the zero-count case, which spends a single idle EXEC cycle
    assign exec_last = cmd_q == CMD_LOAD || remain <= W'(1);
    always_comb begin
        nxt = (state == S_IDLE) ? (any ? S_EXEC : S_IDLE) :
              (state == S_EXEC) ? (exec_last ? S_DONE : S_EXEC) : S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            rr <= '0;
            grant <= '0;
            ack <= '0;
            cmd_q <= CMD_LOAD;
            arg_q <= '0;
            remain <= '0;
        end else begin
            state <= nxt;
            ack <= (state == S_EXEC && exec_last) ? grant : '0;
            if (state == S_IDLE && any) begin
                grant <= win;
                cmd_q <= cmd_t'(cmd[2*int'(win_idx) +: 2]);
                arg_q <= arg[W*int'(win_idx) +: W];
                remain <= arg[W*int'(win_idx) +: W];
            end else if (state == S_EXEC) begin
                remain <= (remain == '0) ? '0 : remain - W'(1);
            end else if (state == S_DONE) begin
                grant <= '0;
                rr <= (g_idx == RW'(N_REQ - 1)) ? '0 : g_idx + RW'(1);
            end
        end
    end
    assign busy     = state != S_IDLE;
    assign ctr_en   = state == S_EXEC && (cmd_q == CMD_LOAD || remain != '0);
    assign ctr_load = ctr_en && cmd_q == CMD_LOAD;
    assign ctr_up   = ctr_en && cmd_q == CMD_UP;
    assign ctr_down = ctr_en && cmd_q == CMD_DOWN;
    assign ctr_hold = ctr_en && cmd_q == CMD_HOLD;
    assign ctr_init = ctr_load ? arg_q : '0;
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed checks of the scheduler against a behavioural counter
module tb_counter_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] req = '0;
    logic [3:0] cmd = '0;
    logic [7:0] arg = '0;
    logic [1:0] grant, ack;
    logic busy, ctr_en, ctr_load, ctr_hold, ctr_up, ctr_down;
    logic [3:0] ctr_init;
    logic [3:0] cval;
    int vecs = 0;
    int errs = 0;
    always #5 clk = ~clk;
    counter_scheduler #(.N_REQ(2), .W(4)) dut (
        .clk(clk), .reset(reset), .req(req), .cmd(cmd), .arg(arg),
        .grant(grant), .ack(ack), .busy(busy),
        .ctr_en(ctr_en), .ctr_load(ctr_load), .ctr_hold(ctr_hold),
        .ctr_up(ctr_up), .ctr_down(ctr_down), .ctr_init(ctr_init)
    );
    // the shared counter: no reset of its own
    always @(posedge clk)
        if (ctr_en) cval <= ctr_load ? ctr_init : ctr_up ? cval + 4'd1 : ctr_down ? cval - 4'd1 : cval;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_req(input int i, input int c, input int a);
        req[i] = 1'b1;
        cmd[2*i +: 2] = 2'(c);
        arg[4*i +: 4] = 4'(a);
    endtask
    task automatic start(input int i, input int c, input int a);
        set_req(i, c, a);
        tick();
        req[i] = 1'b0;
    endtask
    task automatic wait_ack(output int cyc, output int en, output logic [1:0] a);
        cyc = 1;
        en = 0;
        while (ack === 2'b00 && cyc < 40) begin
            en += int'(ctr_en);
            tick();
            cyc++;
        end
        a = ack;
        tick();
    endtask
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vecs++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_grant: got %b expected 00", grant); end
        vecs++; if (ack !== 2'b00) begin errs++; $display("FAIL reset_ack: got %b expected 00", ack); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vecs++; if ({ctr_en, ctr_load, ctr_hold, ctr_up, ctr_down} !== 5'b0) begin errs++; $display("FAIL reset_ctrl: got %b expected 00000", {ctr_en, ctr_load, ctr_hold, ctr_up, ctr_down}); end
        vecs++; if (ctr_init !== 4'd0) begin errs++; $display("FAIL reset_init: got %0d expected 0", ctr_init); end
        reset = 1'b0;
        tick();
    endtask
    task automatic test_load_timing();
        start(0, 0, 2);
        vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL load_grant: got %b expected 01", grant); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL load_busy: got %b expected 1", busy); end
        vecs++; if ({ctr_en, ctr_load} !== 2'b11) begin errs++; $display("FAIL load_ctrl: got %b expected 11", {ctr_en, ctr_load}); end
        vecs++; if (ctr_init !== 4'd2) begin errs++; $display("FAIL load_init: got %0d expected 2", ctr_init); end
        tick();
        vecs++; if (ack !== 2'b01) begin errs++; $display("FAIL load_ack: got %b expected 01", ack); end
        vecs++; if (ctr_load !== 1'b0) begin errs++; $display("FAIL load_once: got %b expected 0", ctr_load); end
        tick();
        vecs++; if (cval !== 4'd2) begin errs++; $display("FAIL load_value: got %0d expected 2", cval); end
        vecs++; if ({ack, grant} !== 4'b0) begin errs++; $display("FAIL load_release: got %b expected 0000", {ack, grant}); end
    endtask
    task automatic test_reset_mid_up();
        start(0, 1, 3);
        vecs++; if (ctr_up !== 1'b1) begin errs++; $display("FAIL midup_up: got %b expected 1", ctr_up); end
        tick();
        reset = 1'b1;
        tick();
        vecs++; if ({grant, ack, busy} !== 5'b0) begin errs++; $display("FAIL midup_outs: got %b expected 00000", {grant, ack, busy}); end
        vecs++; if ({ctr_en, ctr_up, ctr_init} !== 6'b0) begin errs++; $display("FAIL midup_ctrl: got %b expected 000000", {ctr_en, ctr_up, ctr_init}); end
        vecs++; if (cval !== 4'd4) begin errs++; $display("FAIL midup_value: got %0d expected 4", cval); end
        reset = 1'b0;
        tick();
        vecs++; if ({ack, busy} !== 3'b0) begin errs++; $display("FAIL midup_noack: got %b expected 000", {ack, busy}); end
    endtask
    task automatic test_round_robin();
        int cyc, en;
        logic [1:0] a;
        start(1, 0, 2);
        wait_ack(cyc, en, a);
        vecs++; if (a !== 2'b10) begin errs++; $display("FAIL rr_setup_ack: got %b expected 10", a); end
        set_req(0, 1, 2);
        set_req(1, 2, 1);
        tick();
        vecs++; if (grant !== 2'b01) begin errs++; $display("FAIL rr_first: got %b expected 01", grant); end
        req[0] = 1'b0;
        wait_ack(cyc, en, a);
        vecs++; if (a !== 2'b01) begin errs++; $display("FAIL rr_ack0: got %b expected 01", a); end
        vecs++; if (cyc != 3) begin errs++; $display("FAIL rr_lat0: got %0d expected 3", cyc); end
        vecs++; if (cval !== 4'd4) begin errs++; $display("FAIL rr_val0: got %0d expected 4", cval); end
        tick();
        vecs++; if (grant !== 2'b10) begin errs++; $display("FAIL rr_second: got %b expected 10", grant); end
        req[1] = 1'b0;
        wait_ack(cyc, en, a);
        vecs++; if (a !== 2'b10) begin errs++; $display("FAIL rr_ack1: got %b expected 10", a); end
        vecs++; if (cyc != 2) begin errs++; $display("FAIL rr_lat1: got %0d expected 2", cyc); end
        vecs++; if (cval !== 4'd3) begin errs++; $display("FAIL rr_val1: got %0d expected 3", cval); end
    endtask
    task automatic test_wrap();
        int cyc, en;
        logic [1:0] a;
        start(0, 0, 15);
        wait_ack(cyc, en, a);
        vecs++; if (cval !== 4'd15) begin errs++; $display("FAIL wrap_load: got %0d expected 15", cval); end
        start(0, 1, 1);
        wait_ack(cyc, en, a);
        vecs++; if (cyc != 2) begin errs++; $display("FAIL wrap_up_lat: got %0d expected 2", cyc); end
        vecs++; if (cval !== 4'd0) begin errs++; $display("FAIL wrap_up_val: got %0d expected 0", cval); end
        start(0, 2, 2);
        wait_ack(cyc, en, a);
        vecs++; if (cyc != 3) begin errs++; $display("FAIL wrap_down_lat: got %0d expected 3", cyc); end
        vecs++; if (en != 2) begin errs++; $display("FAIL wrap_down_en: got %0d expected 2", en); end
        vecs++; if (cval !== 4'd14) begin errs++; $display("FAIL wrap_down_val: got %0d expected 14", cval); end
    endtask
    task automatic test_zero();
        int cyc, en;
        logic [1:0] a;
        start(0, 3, 0);
        wait_ack(cyc, en, a);
        vecs++; if (en != 0) begin errs++; $display("FAIL zero_hold_en: got %0d expected 0", en); end
        vecs++; if (cyc != 2) begin errs++; $display("FAIL zero_hold_lat: got %0d expected 2", cyc); end
        start(1, 1, 0);
        wait_ack(cyc, en, a);
        vecs++; if (en != 0) begin errs++; $display("FAIL zero_up_en: got %0d expected 0", en); end
        vecs++; if (cyc != 2) begin errs++; $display("FAIL zero_up_lat: got %0d expected 2", cyc); end
        vecs++; if (a !== 2'b10) begin errs++; $display("FAIL zero_up_ack: got %b expected 10", a); end
        vecs++; if (cval !== 4'd14) begin errs++; $display("FAIL zero_value: got %0d expected 14", cval); end
    endtask
    task automatic test_back_to_back();
        int cyc, en;
        logic [1:0] a;
        logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
        set_req(0, 3, 1);
        set_req(1, 3, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++; if (grant !== exp_g[k]) begin errs++; $display("FAIL b2b_grant%0d: got %b expected %b", k, grant, exp_g[k]); end
            wait_ack(cyc, en, a);
            vecs++; if (a !== exp_g[k]) begin errs++; $display("FAIL b2b_ack%0d: got %b expected %b", k, a, exp_g[k]); end
            vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_idle%0d: got %b expected 0", k, busy); end
        end
        req = '0;
        tick();
        vecs++; if (cval !== 4'd14) begin errs++; $display("FAIL b2b_value: got %0d expected 14", cval); end
    endtask
    initial begin
        test_reset();
        test_load_timing();
        test_reset_mid_up();
        test_round_robin();
        test_wrap();
        test_zero();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
